score_display_ctrl: RTL

Score controller for the whack game's physical score readout. It takes hit and miss event pulses from game logic and keeps a two-digit BCD score (00-99) and a session high score. It sequences the game phases and drives the ones and tens nibbles, plus per-digit blank flags, into two HexDecoder instances on the 7-segment display. It replaces the free-running binary DisplayCounter so the display reads true decimal.

---
 rtl/score_display_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/score_display_ctrl.sv
// Two-digit BCD score keeper and game-phase sequencer feeding the two HexDecoder digits.
// Tracks a session high score, blinks the display on a new high, and blanks the leading zero.
module score_display_ctrl #(
  parameter int BLINK_TICKS     = 25000000,
  parameter bit MISS_PENALTY_EN = 1'b1
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Start,
  input  logic       GameOver,
  input  logic       Hit,
  input  logic       Miss,
  input  logic       ShowHigh,
  output logic [3:0] DigitOnes,
  output logic [3:0] DigitTens,
  output logic       BlankOnes,
  output logic       BlankTens,
  output logic       NewHigh,
  output logic [1:0] Phase
);

  localparam int CNT_W = $clog2(BLINK_TICKS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLAY   = 2'd1,
    COMMIT = 2'd2,
    OVER   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       score_tens_q, score_tens_d, score_ones_q, score_ones_d;
  logic [3:0]       high_tens_q, high_tens_d, high_ones_q, high_ones_d;
  logic             new_high_q, new_high_d;
  logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             blink_hidden_q, blink_hidden_d;
  logic [3:0]       digit_ones_q, digit_ones_d, digit_tens_q, digit_tens_d;
  logic             blank_ones_q, blank_ones_d, blank_tens_q, blank_tens_d;

  logic       miss_eff;
  logic       score_beats_high;
  logic [3:0] inc_tens, inc_ones, dec_tens, dec_ones;
  logic       show_high, hidden;
  logic [3:0] disp_tens, disp_ones;

  // Saturating BCD increment/decrement candidates for the current score
  always_comb begin
    inc_tens = score_tens_q;
    inc_ones = score_ones_q;
    dec_tens = score_tens_q;
    dec_ones = score_ones_q;
    if (!(score_tens_q == 4'd9 && score_ones_q == 4'd9)) begin
      if (score_ones_q == 4'd9) begin
        inc_ones = 4'd0;
        inc_tens = score_tens_q + 4'd1;
      end else begin
        inc_ones = score_ones_q + 4'd1;
      end
    end
    if (!(score_tens_q == 4'd0 && score_ones_q == 4'd0)) begin
      if (score_ones_q == 4'd0) begin
        dec_ones = 4'd9;
        dec_tens = score_tens_q - 4'd1;
      end else begin
        dec_ones = score_ones_q - 4'd1;
      end
    end
  end

  assign miss_eff         = Miss && MISS_PENALTY_EN;
  assign score_beats_high = (score_tens_q > high_tens_q) ||
                            (score_tens_q == high_tens_q && score_ones_q > high_ones_q);

  always_comb begin
    state_d        = state_q;
    score_tens_d   = score_tens_q;
    score_ones_d   = score_ones_q;
    high_tens_d    = high_tens_q;
    high_ones_d    = high_ones_q;
    new_high_d     = new_high_q;
    blink_cnt_d    = blink_cnt_q;
    blink_hidden_d = blink_hidden_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d      = PLAY;
          score_tens_d = 4'd0;
          score_ones_d = 4'd0;
        end
      end
      PLAY: begin
        if (Hit && !miss_eff) begin
          score_tens_d = inc_tens;
          score_ones_d = inc_ones;
        end else if (miss_eff && !Hit) begin
          score_tens_d = dec_tens;
          score_ones_d = dec_ones;
        end
        if (GameOver) state_d = COMMIT;
      end
      COMMIT: begin
        state_d        = OVER;
        blink_cnt_d    = '0;
        blink_hidden_d = 1'b0;
        new_high_d     = score_beats_high;
        if (score_beats_high) begin
          high_tens_d = score_tens_q;
          high_ones_d = score_ones_q;
        end
      end
      OVER: begin
        if (Start) begin
          state_d      = PLAY;
          score_tens_d = 4'd0;
          score_ones_d = 4'd0;
          new_high_d   = 1'b0;
        end else if (blink_cnt_q == CNT_W'(BLINK_TICKS - 1)) begin
          blink_cnt_d    = '0;
          blink_hidden_d = !blink_hidden_q;
        end else begin
          blink_cnt_d = blink_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Display selection; ShowHigh overrides everything, including the blink
  always_comb begin
    show_high    = ShowHigh || (state_q == IDLE);
    hidden       = (state_q == OVER) && new_high_q && blink_hidden_q && !ShowHigh;
    disp_tens    = show_high ? high_tens_q : score_tens_q;
    disp_ones    = show_high ? high_ones_q : score_ones_q;
    digit_tens_d = disp_tens;
    digit_ones_d = disp_ones;
    blank_ones_d = hidden;
    blank_tens_d = hidden || (disp_tens == 4'd0);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q        <= IDLE;
      score_tens_q   <= 4'd0;
      score_ones_q   <= 4'd0;
      high_tens_q    <= 4'd0;
      high_ones_q    <= 4'd0;
      new_high_q     <= 1'b0;
      blink_cnt_q    <= '0;
      blink_hidden_q <= 1'b0;
      digit_ones_q   <= 4'd0;
      digit_tens_q   <= 4'd0;
      blank_ones_q   <= 1'b0;
      blank_tens_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      score_tens_q   <= score_tens_d;
      score_ones_q   <= score_ones_d;
      high_tens_q    <= high_tens_d;
      high_ones_q    <= high_ones_d;
      new_high_q     <= new_high_d;
      blink_cnt_q    <= blink_cnt_d;
      blink_hidden_q <= blink_hidden_d;
      digit_ones_q   <= digit_ones_d;
      digit_tens_q   <= digit_tens_d;
      blank_ones_q   <= blank_ones_d;
      blank_tens_q   <= blank_tens_d;
    end
  end

  assign DigitOnes = digit_ones_q;
  assign DigitTens = digit_tens_q;
  assign BlankOnes = blank_ones_q;
  assign BlankTens = blank_tens_q;
  assign NewHigh   = new_high_q;
  assign Phase     = state_q;

endmodule
